// File: rtl/affine_pkg.sv
// Constants and types shared by the affine MV pipeline: the sub-block scanner, the
// transform stage and the MV collector.
package affine_pkg;

    localparam int S_MIN      = 3;
    localparam int S_MAX      = 6;
    localparam int SB_LOG2    = 2;
    localparam int LAT        = 2;
    localparam int CENTRE_OFF = 2;
    localparam int IDX_W      = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    typedef struct packed {
        logic             valid;
        logic             last;
        logic [IDX_W-1:0] idx;
    } tag_t;

    function automatic logic s_legal(input logic [3:0] s);
        return (s >= 4'(S_MIN)) && (s <= 4'(S_MAX));
    endfunction

endpackage

// File: rtl/affine_tag_delay.sv
// DEPTH-stage shift register carrying {valid,last,idx} alongside the fixed-latency
// transform, so each tag leaves on the same cycle as its transform result.
module affine_tag_delay
    import affine_pkg::*;
#(
    parameter int DEPTH = affine_pkg::LAT
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag,
    output tag_t delayed,
    output logic pending
);

    tag_t stage [DEPTH];

    // NOTE: the tag array is reset, because a mid-scan reset must drop in-flight tags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= tag;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign delayed = stage[DEPTH-1];

    // Tags still travelling towards the output stage.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) pending = pending | stage[i].valid;
    end

endmodule

// File: rtl/affine_subblock_scanner.sv
// Walks a 2^S x 2^S coding unit in 4x4 sub-blocks, one per clock, feeding sub-block
// centres to the affine transform and tagging its results for the MV collector.
module affine_subblock_scanner #(
    parameter int WIDTH   = 8,
    parameter int SB_LOG2 = affine_pkg::SB_LOG2,
    parameter int LAT     = affine_pkg::LAT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cu_valid,
    output logic                    cu_ready,
    input  logic [3:0]              cu_S,
    input  logic signed [WIDTH-1:0] cu_mv0_h,
    input  logic signed [WIDTH-1:0] cu_mv1_h,
    input  logic signed [WIDTH-1:0] cu_mv0_v,
    input  logic signed [WIDTH-1:0] cu_mv1_v,
    output logic [3:0]              at_S,
    output logic signed [WIDTH-1:0] at_x,
    output logic signed [WIDTH-1:0] at_y,
    output logic signed [WIDTH-1:0] at_mv0_h,
    output logic signed [WIDTH-1:0] at_mv1_h,
    output logic signed [WIDTH-1:0] at_mv0_v,
    output logic signed [WIDTH-1:0] at_mv1_v,
    output logic                    out_valid,
    output logic                    out_last,
    output logic [7:0]              out_idx,
    output logic                    busy,
    output logic                    err
);
    import affine_pkg::*;

    localparam int CW = S_MAX - SB_LOG2;

    state_t                  state, state_nxt;
    logic [3:0]              s_q, shamt;
    logic signed [WIDTH-1:0] mv0_h_q, mv1_h_q, mv0_v_q, mv1_v_q;
    logic [CW-1:0]           cx, cy, n_max;
    logic                    last_issue, accept, take, pending;
    tag_t                    issue_q, tag_out;

    function automatic logic signed [WIDTH-1:0] centre(input logic [CW-1:0] c);
        return WIDTH'((int'(c) << SB_LOG2) + CENTRE_OFF);
    endfunction

    assign shamt      = s_q - 4'(SB_LOG2);
    assign n_max      = CW'((32'd1 << shamt) - 32'd1);
    assign last_issue = (state == SCAN) && (cx == n_max) && (cy == n_max);
    assign cu_ready   = (state == IDLE) || last_issue;
    assign accept     = cu_valid && cu_ready;
    assign take       = accept && s_legal(cu_S);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // NOTE: state_nxt gets a default first, so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = SCAN;
            SCAN:    if (last_issue && !take) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q      <= '0;
            mv0_h_q  <= '0;
            mv1_h_q  <= '0;
            mv0_v_q  <= '0;
            mv1_v_q  <= '0;
            cx       <= '0;
            cy       <= '0;
            at_S     <= '0;
            at_x     <= '0;
            at_y     <= '0;
            at_mv0_h <= '0;
            at_mv1_h <= '0;
            at_mv0_v <= '0;
            at_mv1_v <= '0;
            issue_q  <= '0;
            err      <= 1'b0;
        end else begin
            err     <= accept && !s_legal(cu_S);
            issue_q <= '0;
            if (state == SCAN) begin
                at_S     <= s_q;
                at_x     <= centre(cx);
                at_y     <= centre(cy);
                at_mv0_h <= mv0_h_q;
                at_mv1_h <= mv1_h_q;
                at_mv0_v <= mv0_v_q;
                at_mv1_v <= mv1_v_q;
                issue_q  <= '{valid: 1'b1, last: last_issue,
                              idx: IDX_W'((int'(cy) << shamt) | int'(cx))};
                if (cx == n_max) begin
                    cx <= '0;
                    cy <= cy + CW'(1);
                end else begin
                    cx <= cx + CW'(1);
                end
            end
            // An accept on the last issue overrides the counter step: no bubble.
            if (take) begin
                s_q     <= cu_S;
                mv0_h_q <= cu_mv0_h;
                mv1_h_q <= cu_mv1_h;
                mv0_v_q <= cu_mv0_v;
                mv1_v_q <= cu_mv1_v;
                cx      <= '0;
                cy      <= '0;
            end
        end
    end

    affine_tag_delay #(.DEPTH(LAT)) u_tag_delay (
        .clk     (clk),
        .rst     (rst),
        .tag     (issue_q),
        .delayed (tag_out),
        .pending (pending)
    );

    assign out_valid = tag_out.valid;
    assign out_last  = tag_out.last;
    assign out_idx   = tag_out.idx;
    assign busy      = (state == SCAN) || issue_q.valid || pending;

endmodule

// File: doc/affine_subblock_scanner.md
Name: affine_subblock_scanner

Overview:
- Upstream feeder of the affine MV transform stage; accepts one coding-unit (CU) descriptor at a time: log2 size S plus two control-point MVs (mv0, mv1, h/v).
- Scans the square 2^S x 2^S CU in 4x4 sub-blocks, raster order, one sub-block per clock, and drives the transform's S/x/y/mv inputs with each sub-block's centre coordinate.
- The transform has fixed 2-cycle latency and no handshake, so this block also carries a matching delay line. That delay line tags each transform result with valid/last/index for the MV collector downstream.

Parameters:
- WIDTH, 8, signed width of coordinates and MV components (matches transform).
- SB_LOG2, 2, log2 of sub-block edge (4x4 sub-blocks).
- LAT, 2, transform latency in cycles; depth of the tag delay line.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset (asserted at 0).
- cu_valid  in  1  descriptor valid.
- cu_ready  out  1  descriptor accept; transfer when cu_valid & cu_ready at a rising edge.
- cu_S  in  4  log2 CU edge; legal 3..6.
- cu_mv0_h, cu_mv1_h, cu_mv0_v, cu_mv1_v  in  WIDTH each  signed control-point MVs.
- at_S  out  4  to transform in_S (registered).
- at_x, at_y  out  WIDTH each  signed sub-block centre to transform in_x/in_y (registered).
- at_mv0_h, at_mv1_h, at_mv0_v, at_mv1_v  out  WIDTH each  latched MVs to transform (registered).
- out_valid  out  1  transform output for a scanned sub-block is present this cycle.
- out_last  out  1  with out_valid: last sub-block of the CU.
- out_idx  out  8  with out_valid: raster index of the sub-block (0..255).
- busy  out  1  SCAN state, or any tag in flight.
- err  out  1  one-cycle pulse: illegal cu_S rejected.

Behaviour:
- Reset (rst=0, async) sets state IDLE, counters 0, all at_* 0, out_valid/out_last/err 0, out_idx 0, and clears the delay line. Mid-scan reset discards the CU; no out_valid for in-flight sub-blocks.
- cu_ready = (state==IDLE) | last_issue. It is combinational, and is 1 during and after reset.
- FSM IDLE to SCAN: accept with legal S. Latch S and MVs. Set the column counter cx=0 and the row counter cy=0.
- Illegal S (<3 or >6) on accept: descriptor dropped, err=1 next cycle, state remains IDLE, nothing issued.
- SCAN, one issue per cycle. At each edge, at_x = (cx<<SB_LOG2)+2 and at_y = (cy<<SB_LOG2)+2, sign-extended to WIDTH; at_S and at_mv* hold the latched values.
- Issue register is set in the cycle the values appear on at_*. It holds issue_valid, issue_last and idx = cy*N+cx, where N = 2^(S-SB_LOG2).
- Counters: cx increments. At cx==N-1, cx wraps to 0 and cy increments. last_issue is true when cx==N-1 & cy==N-1.
- On last_issue: with a new accept, the block re-latches the new CU and restarts at 0,0 with no bubble; otherwise it returns to IDLE.
- Tag delay line is LAT stages of {valid,last,idx} fed from the issue register, so out_* align exactly with the transform's registered output. First out_valid occurs LAT cycles after the first at_* update.
- IDLE: at_* hold their last values. issue_valid=0.
- Sub-blocks per CU = N^2, from 4 (S=3) to 256 (S=6). out_idx wraps never; the maximum is 255.
- cu_valid while busy and not last_issue: not accepted; the descriptor must be held.

Decomposition:
- Shared package affine_pkg: S_MIN=3, S_MAX=6, SB_LOG2, LAT, state encoding (IDLE, SCAN), and centre offset constant 2. The transform stage and the collector reuse it.
- One sub-module, affine_tag_delay: a parameterised LAT-stage shift register of {valid,last,idx} with async active-low clear.

Test Plan:
- Accept S=3, mv0_h=4, mv1_h=8: at_(x,y) = (2,2),(6,2),(2,6),(6,6) on 4 consecutive cycles. out_valid is high for 4 cycles starting 2 cycles later, idx 0..3, out_last only with idx 3. cu_ready is high on the 4th issue cycle.
- Accept S=6: 256 issues. The final at_x=at_y=62, idx 255 with out_last. busy drops 2 cycles after the last issue.
- Back-to-back S=4 then S=3, cu_valid held: the second accept coincides with the 16th issue. The next cycle shows at=(2,2) with the new MVs. out_valid is continuous for 20 cycles.
- cu_S=2, then cu_S=7: each is accepted and dropped, err pulses 1 cycle, out_valid never asserts, state stays IDLE.
- Assert rst=0 after the 5th issue of an S=4 CU: all outputs go to 0 immediately, with no further out_valid. After release, cu_ready=1 and a fresh S=3 scans correctly.
- cu_valid asserted mid-scan of S=4 at issue 3: cu_ready=0 until issue 16, then accepted; no descriptor is lost or duplicated.
